// File: rtl/alu_writeback_pipe_pkg.sv
// rtl/alu_writeback_pipe_pkg.sv - shared constants, forwarding encodings and stage record
//
// Contents:
//   ALUWB_DATA_W / ALUWB_REG_AW  default datapath and register-address widths
//   XZR                          index of the zero register (writes discarded)
//   fwd_sel_e                    operand source select: RF / WB / MEM
//   stage_t                      pipeline stage record {valid, result, rd, regwrite, memtoreg}
package alu_writeback_pipe_pkg;

    localparam int ALUWB_DATA_W = 64;
    localparam int ALUWB_REG_AW = 5;
    localparam int XZR          = 31;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic                    valid;
        logic [ALUWB_DATA_W-1:0] result;
        logic [ALUWB_REG_AW-1:0] rd;
        logic                    regwrite;
        logic                    memtoreg;
    } stage_t;

endpackage

// File: rtl/alu_writeback_pipe_fwd_select.sv
// rtl/alu_writeback_pipe_fwd_select.sv - one operand forwarding select from MEM/WB stage fields
//
// Ports:
//   src         decode-stage source register index
//   m_valid, m_regwrite, m_memtoreg, m_rd   MEM stage fields
//   w_valid, w_regwrite, w_rd               WB stage fields
//   sel         FWD_RF / FWD_WB / FWD_MEM
module fwd_select
    import alu_writeback_pipe_pkg::*;
#(
    parameter int REG_AW   = ALUWB_REG_AW,
    parameter int ZERO_REG = XZR
) (
    input  logic [REG_AW-1:0] src,
    input  logic              m_valid,
    input  logic              m_regwrite,
    input  logic              m_memtoreg,
    input  logic [REG_AW-1:0] m_rd,
    input  logic              w_valid,
    input  logic              w_regwrite,
    input  logic [REG_AW-1:0] w_rd,
    output logic [1:0]        sel
);

    localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);

    logic mem_hit;
    logic wb_hit;

    // A load in MEM has no data yet, so it is never a MEM candidate; the
    // hazard unit stalls decode instead. Once it reaches WB it forwards normally.
    assign mem_hit = m_valid & m_regwrite & ~m_memtoreg & (m_rd != ZR) & (m_rd == src);
    assign wb_hit  = w_valid & w_regwrite & (w_rd != ZR) & (w_rd == src);

    always_comb begin
        sel = FWD_RF;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/alu_writeback_pipe.sv
// rtl/alu_writeback_pipe.sv - MEM/WB pipeline registers, register-file write port, forwarding and load-use detection
//
// Optional feature macro: ALUWB_RETIRE_CNT_EN (retired-instruction counter).
//
// Ports:
//   clock, reset                 rising-edge clock, asynchronous active-high reset
//   ex_valid, ex_result, ex_rd, ex_regwrite, ex_memtoreg   instruction leaving EX
//   mem_rdata                    data memory read data for the instruction in MEM
//   stall                        hold MEM, insert bubble into WB
//   flush                        kill the instruction entering MEM (wins over stall)
//   id_rn, id_rm                 decode-stage source registers
//   WriteReg, WriteData, RegWrite   register file write port (from WB stage)
//   fwd_a, fwd_b                 operand source selects
//   load_use                     decode must stall one cycle
//   retired_count                WB retirements (0 when feature disabled)
module alu_writeback_pipe
    import alu_writeback_pipe_pkg::*;
#(
    parameter int DATA_W   = ALUWB_DATA_W,
    parameter int REG_AW   = ALUWB_REG_AW,
    parameter int ZERO_REG = XZR
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic              ex_memtoreg,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              stall,
    input  logic              flush,
    input  logic [REG_AW-1:0] id_rn,
    input  logic [REG_AW-1:0] id_rm,
    output logic [REG_AW-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic              RegWrite,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              load_use,
    output logic [31:0]       retired_count
);

    localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);

    // The stage record is sized by the package widths; DATA_W/REG_AW must match them.
    stage_t            m_stage;
    stage_t            w_stage;
    logic [DATA_W-1:0] w_rdata;

    // MEM stage: flush kills the incoming instruction even while stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_stage <= '0;
        end else if (flush || !stall) begin
            m_stage.valid    <= ex_valid & ~flush;
            m_stage.result   <= ex_result;
            m_stage.rd       <= ex_rd;
            m_stage.regwrite <= ex_regwrite;
            m_stage.memtoreg <= ex_memtoreg;
        end
    end

    // WB stage: a held MEM instruction must only be written once, so the
    // copy taken while stalled is marked invalid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_stage <= '0;
            w_rdata <= '0;
        end else begin
            w_stage       <= m_stage;
            w_stage.valid <= m_stage.valid & ~stall;
            w_rdata       <= mem_rdata;
        end
    end

    assign RegWrite  = w_stage.valid & w_stage.regwrite & (w_stage.rd != ZR);
    assign WriteReg  = w_stage.rd;
    assign WriteData = w_stage.memtoreg ? w_rdata : w_stage.result;

    assign load_use = m_stage.valid & m_stage.regwrite & m_stage.memtoreg
                    & (m_stage.rd != ZR)
                    & ((m_stage.rd == id_rn) | (m_stage.rd == id_rm));

    fwd_select #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_fwd_a (
        .src        (id_rn),
        .m_valid    (m_stage.valid),
        .m_regwrite (m_stage.regwrite),
        .m_memtoreg (m_stage.memtoreg),
        .m_rd       (m_stage.rd),
        .w_valid    (w_stage.valid),
        .w_regwrite (w_stage.regwrite),
        .w_rd       (w_stage.rd),
        .sel        (fwd_a)
    );

    fwd_select #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_fwd_b (
        .src        (id_rm),
        .m_valid    (m_stage.valid),
        .m_regwrite (m_stage.regwrite),
        .m_memtoreg (m_stage.memtoreg),
        .m_rd       (m_stage.rd),
        .w_valid    (w_stage.valid),
        .w_regwrite (w_stage.regwrite),
        .w_rd       (w_stage.rd),
        .sel        (fwd_b)
    );

`ifdef ALUWB_RETIRE_CNT_EN
    // Counts every WB-valid instruction, including XZR and non-writing ones.
    logic [31:0] retire_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retire_q <= '0;
        end else if (w_stage.valid) begin
            retire_q <= retire_q + 32'd1;
        end
    end

    assign retired_count = retire_q;
`else
    assign retired_count = '0;
`endif

endmodule

// File: tb/tb_alu_writeback_pipe.sv
// tb/tb_alu_writeback_pipe.sv - directed self-checking bench for alu_writeback_pipe
module tb_alu_writeback_pipe;

    logic        clock = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [63:0] ex_result;
    logic [4:0]  ex_rd;
    logic        ex_regwrite;
    logic        ex_memtoreg;
    logic [63:0] mem_rdata;
    logic        stall;
    logic        flush;
    logic [4:0]  id_rn;
    logic [4:0]  id_rm;
    logic [4:0]  WriteReg;
    logic [63:0] WriteData;
    logic        RegWrite;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        load_use;
    logic [31:0] retired_count;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses;

    alu_writeback_pipe dut (
        .clock         (clock),
        .reset         (reset),
        .ex_valid      (ex_valid),
        .ex_result     (ex_result),
        .ex_rd         (ex_rd),
        .ex_regwrite   (ex_regwrite),
        .ex_memtoreg   (ex_memtoreg),
        .mem_rdata     (mem_rdata),
        .stall         (stall),
        .flush         (flush),
        .id_rn         (id_rn),
        .id_rm         (id_rm),
        .WriteReg      (WriteReg),
        .WriteData     (WriteData),
        .RegWrite      (RegWrite),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .load_use      (load_use),
        .retired_count (retired_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_ex(input logic v, input logic [4:0] rd, input logic [63:0] res,
                          input logic rw, input logic m2r);
        ex_valid    = v;
        ex_rd       = rd;
        ex_result   = res;
        ex_regwrite = rw;
        ex_memtoreg = m2r;
    endtask

    task automatic idle();
        set_ex(1'b0, 5'd0, 64'd0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        mem_rdata = '0; id_rn = 5'd0; id_rm = 5'd0;
        idle();
        #2;
        check("rst_regwrite",  {63'd0, RegWrite}, 64'd0);
        check("rst_writereg",  {59'd0, WriteReg}, 64'd0);
        check("rst_writedata", WriteData, 64'd0);
        check("rst_fwd",       {60'd0, fwd_a, fwd_b}, 64'd0);
        check("rst_load_use",  {63'd0, load_use}, 64'd0);
        check("rst_retired",   {32'd0, retired_count}, 64'd0);
        step();
        reset = 1'b0;
        step();

        // Single ADD to X3: visible on the write port two edges after sampling.
        set_ex(1'b1, 5'd3, 64'h5, 1'b1, 1'b0);
        step();
        idle();
        check("add_in_mem_no_write", {63'd0, RegWrite}, 64'd0);
        step();
        check("add_regwrite",  {63'd0, RegWrite}, 64'd1);
        check("add_writereg",  {59'd0, WriteReg}, 64'd3);
        check("add_writedata", WriteData, 64'h5);
        step();
        check("add_one_cycle", {63'd0, RegWrite}, 64'd0);

        // Back-to-back forwarding.
        set_ex(1'b1, 5'd3, 64'h11, 1'b1, 1'b0);
        step();
        set_ex(1'b1, 5'd5, 64'h22, 1'b1, 1'b0);
        id_rn = 5'd3; id_rm = 5'd0;
        #1;
        check("fwd_a_mem", {62'd0, fwd_a}, 64'd2);
        check("fwd_b_rf",  {62'd0, fwd_b}, 64'd0);
        step();
        idle();
        id_rn = 5'd1; id_rm = 5'd3;
        #1;
        check("fwd_b_wb", {62'd0, fwd_b}, 64'd1);
        check("fwd_a_rf", {62'd0, fwd_a}, 64'd0);
        step();
        step();

        // MEM beats WB when both target the same register.
        set_ex(1'b1, 5'd3, 64'hA, 1'b1, 1'b0);
        step();
        set_ex(1'b1, 5'd3, 64'hB, 1'b1, 1'b0);
        step();
        idle();
        id_rn = 5'd3; id_rm = 5'd7;
        #1;
        check("fwd_a_mem_priority", {62'd0, fwd_a}, 64'd2);
        step();
        step();

        // Load to X4: load-use hazard in MEM, memory data written at WB.
        set_ex(1'b1, 5'd4, 64'h99, 1'b1, 1'b1);
        step();
        idle();
        mem_rdata = 64'hDEAD;
        id_rn = 5'd0; id_rm = 5'd4;
        #1;
        check("load_use_set",     {63'd0, load_use}, 64'd1);
        check("load_fwd_b_not_mem", {62'd0, fwd_b}, 64'd0);
        step();
        mem_rdata = 64'h0;
        #1;
        check("load_regwrite",  {63'd0, RegWrite}, 64'd1);
        check("load_writereg",  {59'd0, WriteReg}, 64'd4);
        check("load_writedata", WriteData, 64'hDEAD);
        check("load_fwd_b_wb",  {62'd0, fwd_b}, 64'd1);
        check("load_use_clear", {63'd0, load_use}, 64'd0);
        step();

        // XZR write is discarded and never forwards.
        set_ex(1'b1, 5'd31, 64'hFF, 1'b1, 1'b0);
        step();
        idle();
        id_rn = 5'd31; id_rm = 5'd31;
        #1;
        check("xzr_fwd_a_mem", {62'd0, fwd_a}, 64'd0);
        step();
        check("xzr_regwrite", {63'd0, RegWrite}, 64'd0);
        check("xzr_fwd_a_wb", {62'd0, fwd_a}, 64'd0);
        step();
        id_rn = 5'd0; id_rm = 5'd0;

        // Stall three cycles with X6 held in MEM: exactly one write.
        set_ex(1'b1, 5'd6, 64'h66, 1'b1, 1'b0);
        step();
        idle();
        stall = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (RegWrite) pulses++;
        end
        check("stall_no_write_while_held", 64'(pulses), 64'd0);
        stall = 1'b0;
        step();
        check("stall_release_write", {63'd0, RegWrite}, 64'd1);
        check("stall_release_data",  WriteData, 64'h66);
        if (RegWrite) pulses++;
        for (int i = 0; i < 3; i++) begin
            step();
            if (RegWrite) pulses++;
        end
        check("stall_single_pulse", 64'(pulses), 64'd1);

        // Flush together with stall drops the instruction.
        set_ex(1'b1, 5'd7, 64'h77, 1'b1, 1'b0);
        flush = 1'b1; stall = 1'b1;
        step();
        flush = 1'b0; stall = 1'b0;
        idle();
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (RegWrite) pulses++;
        end
        check("flush_stall_no_write", 64'(pulses), 64'd0);

        // Asynchronous reset with instructions in MEM and WB.
        set_ex(1'b1, 5'd8, 64'h88, 1'b1, 1'b0);
        step();
        set_ex(1'b1, 5'd9, 64'h99, 1'b1, 1'b0);
        step();
        idle();
        id_rn = 5'd9;
        #1;
        check("pre_reset_write", {63'd0, RegWrite}, 64'd1);
        check("pre_reset_fwd_a", {62'd0, fwd_a}, 64'd2);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_regwrite",  {63'd0, RegWrite}, 64'd0);
        check("async_rst_writereg",  {59'd0, WriteReg}, 64'd0);
        check("async_rst_writedata", WriteData, 64'd0);
        check("async_rst_fwd_a",     {62'd0, fwd_a}, 64'd0);
        check("async_rst_retired",   {32'd0, retired_count}, 64'd0);
        step();
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (RegWrite) pulses++;
        end
        check("post_reset_no_write", 64'(pulses), 64'd0);
        id_rn = 5'd0;

        // Four retirements: normal, XZR, non-writing, load.
        set_ex(1'b1, 5'd1,  64'h1, 1'b1, 1'b0); step();
        set_ex(1'b1, 5'd31, 64'h2, 1'b1, 1'b0); step();
        set_ex(1'b1, 5'd2,  64'h3, 1'b0, 1'b0); step();
        set_ex(1'b1, 5'd10, 64'h4, 1'b1, 1'b1); step();
        idle();
        step(); step(); step();
`ifdef ALUWB_RETIRE_CNT_EN
        check("retired_count_4", {32'd0, retired_count}, 64'd4);
`else
        check("retired_count_off", {32'd0, retired_count}, 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
